// File: rtl/fmc_i2c_target.sv
// fmc_i2c_target: standard-mode I2C target answering on TARGET_ADDR, bridging to an 8-bit register bus
module fmc_i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'b0111110,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       SCL_PIN,
  inout  wire        SDA_PIN,
  output logic [7:0] REG_ADDR,
  output logic [7:0] REG_WDATA,
  output logic       REG_WE,
  input  logic [7:0] REG_RDATA,
  output logic       REG_RE,
  output logic       BUSY
);
  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK
  } state_t;
  state_t r_state, w_next;
  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic r_scl_d, r_sda_d, r_oe, r_rw, r_phase, r_we;
  logic [3:0] r_cnt;
  logic [7:0] r_shift, r_addr, r_wdata;
  logic w_scl, w_sda, w_rise, w_fall, w_start, w_stop, w_last, w_re;
  logic [7:0] w_byte;
  assign SDA_PIN = r_oe ? 1'b0 : 1'bz;
  assign REG_ADDR = r_addr;
  assign REG_WDATA = r_wdata;
  assign REG_WE = r_we;
  assign REG_RE = w_re;
  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];
  assign w_rise = w_scl & ~r_scl_d;
  assign w_fall = ~w_scl & r_scl_d;
  assign w_start = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign w_byte = {r_shift[6:0], w_sda};
  assign w_last = r_cnt == 4'd7;
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
      r_state <= IDLE;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], SCL_PIN};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], SDA_PIN};
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
      r_state <= w_next;
    end
  end
  // bus conditions override every state; ACK states hold the line for one full SCL low/high/low span
  always_comb begin
    w_next = r_state;
    if (w_start) w_next = ADDR;
    else if (w_stop) w_next = IDLE;
    else
      case (r_state)
        ADDR: if (w_rise && w_last) w_next = w_byte[7:1] == TARGET_ADDR ? ADDR_ACK : IDLE;
        PTR: if (w_rise && w_last) w_next = PTR_ACK;
        WDATA: if (w_rise && w_last) w_next = WDATA_ACK;
        ADDR_ACK: if (w_fall && r_phase) w_next = r_rw ? RDATA : PTR;
        PTR_ACK, WDATA_ACK: if (w_fall && r_phase) w_next = WDATA;
        RDATA: if (w_fall && r_cnt == 4'd8) w_next = RACK;
        RACK: w_next = (w_rise && w_sda) ? IDLE : (w_fall && r_phase) ? RDATA : RACK;
        default: w_next = r_state;
      endcase
  end
  always_comb begin
    w_re = !w_start && !w_stop && w_fall && r_phase &&
           ((r_state == ADDR_ACK && r_rw) || r_state == RACK);
    BUSY = r_state != IDLE && r_state != ADDR;
  end
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_oe <= 1'b0;
      r_rw <= 1'b0;
      r_phase <= 1'b0;
      r_we <= 1'b0;
      r_cnt <= 4'd0;
      r_shift <= 8'h00;
      r_addr <= 8'h00;
      r_wdata <= 8'h00;
    end else begin
      r_we <= 1'b0;
      if (r_we) r_addr <= r_addr + 8'd1;
      if (w_start || w_stop) begin
        r_cnt <= 4'd0;
        r_oe <= 1'b0;
        r_phase <= 1'b0;
      end else
        case (r_state)
          ADDR, PTR, WDATA: if (w_rise) begin
            r_shift <= w_byte;
            r_cnt <= w_last ? 4'd0 : r_cnt + 4'd1;
            if (w_last && r_state == ADDR) r_rw <= w_sda;
            if (w_last && r_state == PTR) r_addr <= w_byte;
            if (w_last && r_state == WDATA) begin
              r_we <= 1'b1;
              r_wdata <= w_byte;
            end
          end
          ADDR_ACK, PTR_ACK, WDATA_ACK: if (w_fall) begin
            r_phase <= ~r_phase;
            r_oe <= ~r_phase | (w_re & ~REG_RDATA[7]);
            if (w_re) r_shift <= REG_RDATA;
          end
          RDATA: begin
            if (w_rise) begin
              r_cnt <= r_cnt + 4'd1;
              r_shift <= r_shift << 1;
            end
            if (w_fall) begin
              r_oe <= r_cnt == 4'd8 ? 1'b0 : ~r_shift[7];
              if (r_cnt == 4'd8) r_cnt <= 4'd0;
            end
          end
          RACK: begin
            if (w_rise && !w_sda) begin
              r_phase <= 1'b1;
              r_addr <= r_addr + 8'd1;
            end
            if (w_fall && r_phase) begin
              r_phase <= 1'b0;
              r_shift <= REG_RDATA;
              r_oe <= ~REG_RDATA[7];
              r_cnt <= 4'd0;
            end
          end
          default: r_oe <= 1'b0;
        endcase
    end
  end
endmodule

// File: tb/tb_fmc_i2c_target.sv
// tb_fmc_i2c_target: bit-banged I2C controller driving directed transactions into fmc_i2c_target
module tb_fmc_i2c_target;
  localparam int Q = 10;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, scl, sda_low;
  wire sda_bus;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic reg_we, reg_re, busy;
  pullup (sda_bus);
  assign sda_bus = sda_low ? 1'b0 : 1'bz;
  assign reg_rdata = ~reg_addr;
  fmc_i2c_target dut (
    .CLK(clk), .RESET_N(rst_n), .SCL_PIN(scl), .SDA_PIN(sda_bus),
    .REG_ADDR(reg_addr), .REG_WDATA(reg_wdata), .REG_WE(reg_we),
    .REG_RDATA(reg_rdata), .REG_RE(reg_re), .BUSY(busy)
  );
  int n_tests = 0, n_fail = 0;
  int we_cnt = 0, re_cnt = 0, drive_cnt = 0, busy_cnt = 0;
  logic [7:0] we_addr [64];
  logic [7:0] we_data [64];
  always @(negedge clk) begin
    if (reg_we) begin
      we_addr[we_cnt % 64] = reg_addr;
      we_data[we_cnt % 64] = reg_wdata;
      we_cnt++;
    end
    if (reg_re) re_cnt++;
    if (!sda_low && sda_bus === 1'b0) drive_cnt++;
    if (busy) busy_cnt++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic bus_start;
    sda_low = 1'b0; tick(Q);
    scl = 1'b1; tick(Q);
    sda_low = 1'b1; tick(Q);
    scl = 1'b0; tick(Q);
  endtask
  task automatic bus_stop;
    sda_low = 1'b1; tick(Q);
    scl = 1'b1; tick(Q);
    sda_low = 1'b0; tick(Q);
  endtask
  task automatic put_bit(input logic b);
    sda_low = ~b; tick(Q);
    scl = 1'b1; tick(2 * Q);
    scl = 1'b0; tick(Q);
  endtask
  task automatic get_bit(output logic b);
    sda_low = 1'b0; tick(Q);
    scl = 1'b1; tick(Q);
    b = sda_bus; tick(Q);
    scl = 1'b0; tick(Q);
  endtask
  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack);
  endtask
  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(nack);
  endtask
  initial begin
    logic a;
    logic [7:0] d;
    int wb, rb, db, bb;
    scl = 1'b1; sda_low = 1'b0; rst_n = 1'b0;
    tick(5);
    check("rst_busy", busy, 0);
    check("rst_addr", reg_addr, 8'h00);
    check("rst_wdata", reg_wdata, 8'h00);
    check("rst_we", reg_we, 0);
    check("rst_re", reg_re, 0);
    check("rst_sda", sda_bus, 1);
    rst_n = 1'b1; tick(Q);
    // single write
    wb = we_cnt;
    bus_start;
    send_byte(8'h7C, a); check("t1_ack_addr", a, 0);
    send_byte(8'h05, a); check("t1_ack_ptr", a, 0);
    send_byte(8'hA5, a); check("t1_ack_data", a, 0);
    check("t1_busy", busy, 1);
    bus_stop; tick(Q);
    check("t1_we_cnt", we_cnt - wb, 1);
    check("t1_we_addr", we_addr[wb % 64], 8'h05);
    check("t1_we_data", we_data[wb % 64], 8'hA5);
    check("t1_busy_end", busy, 0);
    check("t1_ptr_inc", reg_addr, 8'h06);
    // burst write wrapping the pointer
    wb = we_cnt;
    bus_start;
    send_byte(8'h7C, a); send_byte(8'hFE, a);
    send_byte(8'h11, a); send_byte(8'h22, a); send_byte(8'h33, a);
    check("t2_ack_last", a, 0);
    bus_stop; tick(Q);
    check("t2_we_cnt", we_cnt - wb, 3);
    check("t2_addr0", we_addr[wb % 64], 8'hFE);
    check("t2_data0", we_data[wb % 64], 8'h11);
    check("t2_addr1", we_addr[(wb + 1) % 64], 8'hFF);
    check("t2_data1", we_data[(wb + 1) % 64], 8'h22);
    check("t2_addr2", we_addr[(wb + 2) % 64], 8'h00);
    check("t2_data2", we_data[(wb + 2) % 64], 8'h33);
    check("t2_final_ptr", reg_addr, 8'h01);
    // random read through repeated START
    wb = we_cnt; rb = re_cnt;
    bus_start;
    send_byte(8'h7C, a); send_byte(8'h10, a);
    bus_start;
    send_byte(8'h7D, a); check("t3_ack_rd", a, 0);
    recv_byte(1'b0, d); check("t3_byte0", d, 8'hEF);
    recv_byte(1'b1, d); check("t3_byte1", d, 8'hEE);
    check("t3_sda_rel", sda_bus, 1);
    check("t3_busy", busy, 0);
    check("t3_re_cnt", re_cnt - rb, 2);
    check("t3_ptr", reg_addr, 8'h11);
    check("t3_no_we", we_cnt - wb, 0);
    bus_stop; tick(Q);
    // address mismatch
    wb = we_cnt; db = drive_cnt; bb = busy_cnt;
    bus_start;
    send_byte(8'hA0, a); check("t4_nack_addr", a, 1);
    send_byte(8'h05, a); check("t4_nack_ptr", a, 1);
    send_byte(8'h12, a); check("t4_nack_data", a, 1);
    bus_stop; tick(Q);
    check("t4_no_drive", drive_cnt - db, 0);
    check("t4_no_busy", busy_cnt - bb, 0);
    check("t4_no_we", we_cnt - wb, 0);
    check("t4_ptr", reg_addr, 8'h11);
    // aborted write, then a normal write
    wb = we_cnt;
    bus_start;
    send_byte(8'h7C, a); send_byte(8'h20, a);
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
    bus_stop; tick(Q);
    check("t5_no_we", we_cnt - wb, 0);
    check("t5_busy", busy, 0);
    check("t5_ptr", reg_addr, 8'h20);
    bus_start;
    send_byte(8'h7C, a); check("t5_ack_addr", a, 0);
    send_byte(8'h30, a); send_byte(8'h5A, a); check("t5_ack_data", a, 0);
    bus_stop; tick(Q);
    check("t5_we_cnt", we_cnt - wb, 1);
    check("t5_we_addr", we_addr[wb % 64], 8'h30);
    check("t5_we_data", we_data[wb % 64], 8'h5A);
    // reset while the target drives a 0 data bit
    bus_start;
    send_byte(8'h7C, a); send_byte(8'hFF, a);
    bus_start;
    send_byte(8'h7D, a);
    sda_low = 1'b0; tick(Q);
    scl = 1'b1; tick(Q);
    check("t6_bit_low", sda_bus, 0);
    rst_n = 1'b0; tick(1);
    check("t6_sda_rel", sda_bus, 1);
    check("t6_busy", busy, 0);
    check("t6_ptr", reg_addr, 8'h00);
    tick(3); rst_n = 1'b1; tick(Q);
    wb = we_cnt;
    bus_start;
    send_byte(8'h7C, a); check("t6_ack_after", a, 0);
    send_byte(8'h42, a); send_byte(8'h99, a);
    bus_stop; tick(Q);
    check("t6_we_cnt", we_cnt - wb, 1);
    check("t6_we_addr", we_addr[wb % 64], 8'h42);
    check("t6_we_data", we_data[wb % 64], 8'h99);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
